fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter MEM_BYTES, 32, size in bytes of the byte-addressable instruction memory; multiple of 4.
REQ-002 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset; word-aligned, < MEM_BYTES.
REQ-003 Parameter WRAP, 1, 1 = PC wraps to 0 past last word; 0 = halt with error past last word.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 imem_addr  output  32  byte address of the word fetched from instruction memory (= PC register).
REQ-007 imem_rdata  input  32  combinational little-endian word {M[a+3],M[a+2],M[a+1],M[a]} for imem_addr.
REQ-008 redirect_valid  input  1  branch/jump request, one cycle.
REQ-009 redirect_pc  input  32  target address, sampled when redirect_valid=1.
REQ-010 halt_req  input  1  stop fetching after the current held instruction drains.
REQ-011 inst_valid  output  1  inst_data/inst_pc hold a valid instruction.
REQ-012 inst_ready  input  1  consumer accepts; transfer when inst_valid & inst_ready.
REQ-013 inst_data  output  32  registered instruction word.
REQ-014 inst_pc  output  32  address inst_data was fetched from.
REQ-015 fetch_err  output  1  sticky: misaligned/out-of-range redirect or end-of-memory with WRAP=0.
REQ-016 fetch_count  output  16  accepted-instruction count, saturating at 16'hFFFF.

Function
REQ-017 FSM states IDLE, FETCH, HALT; IDLE -> FETCH unconditionally one cycle after reset deasserts.
REQ-018 In FETCH, when !inst_valid | inst_ready: inst_data <= imem_rdata, inst_pc <= PC, inst_valid <= 1, PC <= PC+4; else all hold (backpressure; no instruction dropped or duplicated).
REQ-019 Latency: word at imem_addr appears on inst_data with inst_valid=1 exactly one cycle later absent stall.
REQ-020 PC+4 >= MEM_BYTES: WRAP=1 -> PC <= 0; WRAP=0 -> last word still issued, then state HALT, fetch_err <= 1.
REQ-021 Redirect has highest priority in IDLE/FETCH/HALT: PC <= redirect_pc, inst_valid <= 0 next cycle (flush), state FETCH.
REQ-022 Redirect with redirect_pc[1:0]!=0 or redirect_pc > MEM_BYTES-4: PC unchanged, inst_valid <= 0, state HALT, fetch_err <= 1.
REQ-023 Redirect coincident with a transfer: transfer counts (fetch_count increments); flushed word is the one not yet issued.
REQ-024 halt_req in FETCH: no further capture; state HALT once inst_valid=0 (after transfer); held word still delivered.
REQ-025 HALT: inst_valid held 0, PC frozen; exit only via valid redirect.
REQ-026 fetch_count increments on every inst_valid & inst_ready, saturates, never wraps.
REQ-027 fetch_err cleared only by reset.

Reset
REQ-028 reset=1 at a rising edge: state IDLE, PC=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_err=0, fetch_count=0.
REQ-029 Reset overrides redirect, halt_req and any pending transfer; mid-operation reset discards the held instruction.
REQ-030 imem_addr = RESET_PC during and one cycle after reset.

Structure
REQ-031 Package fetch_pkg holds the state enum, INSN_BYTES=4, and the aligned/in-range check function.
REQ-032 One sub-module, pc_gen: PC register, increment, wrap and redirect select; FSM, output register and counter in fetch_ctrl.

Verification
REQ-033 Reset, inst_ready=1, memory 8 words (add/sub/mul/xor/sll/srl/and/or) -> inst_data 0x00940333, 0x413903b3, 0x035a02b3 ... with inst_pc 0,4,8..; after 0x1C, inst_pc 0 again (WRAP=1).
REQ-034 inst_ready=0 for 3 cycles while inst_pc=8 -> inst_data 0x035a02b3 stable, imem_addr stays 12; release -> next word 0x017b4e33, no skip.
REQ-035 redirect_valid=1, redirect_pc=0x14 while inst_pc=4 valid -> inst_valid=0 next cycle, then inst_pc=0x14, inst_data=0x01bd5f33.
REQ-036 redirect_pc=0x06 -> fetch_err=1, state HALT, inst_valid=0; redirect_pc=0x10 -> fetching resumes at 0x10, fetch_err stays 1.
REQ-037 WRAP=0, run to 0x1C -> 0x00f768b3 issued, then HALT, fetch_err=1; reset mid-stream -> fetch_count=0, first issue inst_pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_e : controller FSM states (IDLE, FETCH, HALT)
//   INSN_BYTES    : size of one instruction word in bytes
//   addr_ok()     : true when an address is word-aligned and names a word
//                   that lies entirely inside the instruction memory
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSN_BYTES = 4;

  function automatic logic addr_ok(input logic [31:0] addr,
                                   input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - INSN_BYTES));
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_gen.sv
// Program counter generator for the fetch controller.
// Holds the PC, steps it by one instruction, wraps or freezes at the end of
// memory, and loads a redirect target on request.
//   clk, reset : clock, synchronous active-high reset (PC <= RESET_PC)
//   load       : take load_pc as the next PC (highest priority)
//   load_pc    : redirect target, already validated by the caller
//   advance    : step to the next instruction
//   pc         : current PC
//   last_word  : PC names the final word of memory
module pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          WRAP      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic        last_word
);

  // Widened by one bit so a PC near 2^32 cannot overflow the comparison.
  assign last_word = ({1'b0, pc} + 33'(INSN_BYTES)) >= 33'(MEM_BYTES);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples pre-edge values regardless of block ordering.
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (advance) begin
      if (!last_word)  pc <= pc + 32'(INSN_BYTES);
      else if (WRAP)   pc <= 32'h0;
      // Without wrap the PC freezes on the last word; the FSM halts.
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Presents the PC to a combinational instruction memory, registers the
// returned word with a valid/ready handshake toward the decoder, and handles
// redirects, halt requests and end-of-memory.
//   clk, reset      : clock, synchronous active-high reset
//   imem_addr       : byte address presented to instruction memory (the PC)
//   imem_rdata      : word read combinationally at imem_addr
//   redirect_valid  : one-cycle branch/jump request
//   redirect_pc     : redirect target
//   halt_req        : stop fetching once the held instruction drains
//   inst_valid      : inst_data/inst_pc hold an instruction
//   inst_ready      : consumer accepts the held instruction
//   inst_data       : registered instruction word
//   inst_pc         : address inst_data was fetched from
//   fetch_err       : sticky error (bad redirect, end of memory without wrap)
//   fetch_count     : accepted instructions, saturating
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          WRAP      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  output logic [15:0] fetch_count
);

  fetch_state_e state, state_next;

  logic [31:0] pc;
  logic        last_word;
  logic        transfer;
  logic        redir_ok;
  logic        capture;
  logic        clear_valid;
  logic        set_err;
  logic        pc_load;
  logic        pc_adv;

  pc_gen #(
    .MEM_BYTES (MEM_BYTES),
    .RESET_PC  (RESET_PC),
    .WRAP      (WRAP)
  ) u_pc_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .load_pc   (redirect_pc),
    .advance   (pc_adv),
    .pc        (pc),
    .last_word (last_word)
  );

  assign imem_addr = pc;
  assign transfer  = inst_valid & inst_ready;
  assign redir_ok  = addr_ok(redirect_pc, MEM_BYTES);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_next  = state;
    capture     = 1'b0;
    clear_valid = 1'b0;
    set_err     = 1'b0;
    pc_load     = 1'b0;
    pc_adv      = 1'b0;

    if (redirect_valid) begin
      // Redirect wins in every state; the held word (if not taken this
      // cycle) is the wrong-path one and is flushed.
      clear_valid = 1'b1;
      if (redir_ok) begin
        pc_load    = 1'b1;
        state_next = FETCH;
      end else begin
        set_err    = 1'b1;
        state_next = HALT;
      end
    end else begin
      unique case (state)
        IDLE: state_next = FETCH;

        FETCH: begin
          // Output slot is free, or being emptied this cycle.
          if (!inst_valid || inst_ready) begin
            if (halt_req) begin
              clear_valid = 1'b1;
              state_next  = HALT;
            end else begin
              capture = 1'b1;
              pc_adv  = 1'b1;
              if (last_word && !WRAP) begin
                set_err    = 1'b1;
                state_next = HALT;
              end
            end
          end
        end

        // A final word captured on entry (end of memory) still drains here.
        HALT: if (transfer) clear_valid = 1'b1;

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_valid  <= 1'b0;
      inst_data   <= 32'h0;
      inst_pc     <= 32'h0;
      fetch_err   <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      if (capture) begin
        inst_valid <= 1'b1;
        inst_data  <= imem_rdata;
        inst_pc    <= pc;
      end else if (clear_valid) begin
        inst_valid <= 1'b0;
      end
      if (set_err) fetch_err <= 1'b1;
      if (transfer && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: one wrapping and one non-wrapping
// instance share stimulus; a behavioural model tracks the selected one.
module tb_fetch_ctrl;

  localparam int          MEM_BYTES = 32;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect_valid, halt_req, inst_ready;
  logic [31:0] redirect_pc;

  logic [31:0] w_addr, w_rdata, w_data, w_pc;
  logic        w_valid, w_err;
  logic [15:0] w_count;
  logic [31:0] h_addr, h_rdata, h_data, h_pc;
  logic        h_valid, h_err;
  logic [15:0] h_count;

  logic [31:0] mem [8];
  assign w_rdata = mem[w_addr[4:2]];
  assign h_rdata = mem[h_addr[4:2]];

  fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .inst_valid(w_valid), .inst_ready(inst_ready), .inst_data(w_data), .inst_pc(w_pc),
    .fetch_err(w_err), .fetch_count(w_count));

  fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC), .WRAP(1'b0)) dut_h (
    .clk(clk), .reset(reset), .imem_addr(h_addr), .imem_rdata(h_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .inst_valid(h_valid), .inst_ready(inst_ready), .inst_data(h_data), .inst_pc(h_pc),
    .fetch_err(h_err), .fetch_count(h_count));

  int checks = 0;
  int errors = 0;
  bit sel_h  = 1'b0;

  // Behavioural model: mode 0 = starting, 1 = running, 2 = stopped.
  int          m_mode;
  bit          m_wrap;
  bit          m_valid, m_err;
  logic [31:0] m_pc, m_data, m_ipc;
  int          m_count;

  function automatic logic [113:0] act_vec();
    if (sel_h) return {h_addr, h_valid, h_data, h_pc, h_err, h_count};
    return {w_addr, w_valid, w_data, w_pc, w_err, w_count};
  endfunction

  function automatic logic [113:0] exp_vec();
    return {m_pc, m_valid, m_data, m_ipc, m_err, 16'(m_count)};
  endfunction

  function automatic logic [31:0] act_data();
    return sel_h ? h_data : w_data;
  endfunction
  function automatic logic [31:0] act_ipc();
    return sel_h ? h_pc : w_pc;
  endfunction

  task automatic model_step();
    bit xfer;
    xfer = m_valid && inst_ready;
    if (reset) begin
      m_mode = 0; m_pc = RESET_PC; m_valid = 0; m_data = 0; m_ipc = 0;
      m_err = 0; m_count = 0;
      return;
    end
    if (xfer && m_count < 65535) m_count++;
    if (redirect_valid) begin
      m_valid = 0;
      if (redirect_pc % 4 == 0 && longint'(redirect_pc) < longint'(MEM_BYTES)) begin
        m_pc = redirect_pc; m_mode = 1;
      end else begin
        m_mode = 2; m_err = 1;
      end
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (!m_valid || inst_ready) begin
        if (halt_req) begin
          m_valid = 0; m_mode = 2;
        end else begin
          m_data = mem[m_pc / 4]; m_ipc = m_pc; m_valid = 1;
          if (m_pc + 4 < MEM_BYTES) m_pc = m_pc + 4;
          else if (m_wrap)          m_pc = 0;
          else begin m_mode = 2; m_err = 1; end
        end
      end
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  task automatic drive(input bit rst, input bit rv, input logic [31:0] rpc,
                       input bit hr, input bit rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; halt_req = hr; inst_ready = rdy;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 32'h10, 1, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset act=%h exp=%h", act_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 1);
    tick();
    if ((sel_h ? h_addr : w_addr) !== RESET_PC || (sel_h ? h_valid : w_valid) !== 1'b0) begin
      errors++; $display("FAIL reset_release addr=%h valid=%b exp addr=%h valid=0",
                         sel_h ? h_addr : w_addr, sel_h ? h_valid : w_valid, RESET_PC);
    end
    checks++;
  endtask

  task automatic test_stream();
    logic [31:0] words [8];
    words = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
              32'h00b51533, 32'h01bd5f33, 32'h00c5f633, 32'h00f768b3};
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (w_valid !== 1'b1 || w_data !== words[i % 8] || w_pc !== 32'(4 * (i % 8))) begin
        errors++; $display("FAIL stream[%0d] valid=%b data=%h pc=%h exp data=%h pc=%h",
                           i, w_valid, w_data, w_pc, words[i % 8], 4 * (i % 8));
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL stream_model act=%h exp=%h", act_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  task automatic wait_for_ipc(input logic [31:0] target, input string tag);
    for (int i = 0; i < 20 && !(m_valid && m_ipc == target); i++) tick();
    if (!(m_valid && m_ipc == target)) begin
      errors++; $display("FAIL %s timeout waiting for inst_pc=%h", tag, target);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    drive(0, 0, 0, 0, 1);
    wait_for_ipc(32'h8, "backpressure");
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (w_data !== 32'h035a02b3 || w_valid !== 1'b1 || w_addr !== 32'hC) begin
        errors++; $display("FAIL stall[%0d] data=%h valid=%b addr=%h exp 035a02b3/1/0000000c",
                           i, w_data, w_valid, w_addr);
      end
      checks++;
    end
    drive(0, 0, 0, 0, 1);
    tick();
    if (w_data !== 32'h017b4e33 || w_pc !== 32'hC || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL stall_release data=%h pc=%h exp 017b4e33/0000000c", w_data, w_pc);
    end
    checks++;
  endtask

  task automatic test_redirect();
    int cnt_before;
    drive(0, 0, 0, 0, 1);
    wait_for_ipc(32'h4, "redirect");
    cnt_before = m_count;
    drive(0, 1, 32'h14, 0, 1);
    tick();
    if (w_valid !== 1'b0 || w_count !== 16'(cnt_before + 1)) begin
      errors++; $display("FAIL redirect_flush valid=%b count=%0d exp 0/%0d",
                         w_valid, w_count, cnt_before + 1);
    end
    checks++;
    drive(0, 0, 0, 0, 1);
    tick();
    if (w_valid !== 1'b1 || w_pc !== 32'h14 || w_data !== 32'h01bd5f33) begin
      errors++; $display("FAIL redirect_target valid=%b pc=%h data=%h exp 1/00000014/01bd5f33",
                         w_valid, w_pc, w_data);
    end
    checks++;
  endtask

  task automatic test_bad_redirect();
    drive(0, 1, 32'h6, 0, 1);
    tick();
    if (w_err !== 1'b1 || w_valid !== 1'b0) begin
      errors++; $display("FAIL bad_redirect err=%b valid=%b exp 1/0", w_err, w_valid);
    end
    checks++;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (act_vec() !== exp_vec() || w_valid !== 1'b0) begin
        errors++; $display("FAIL halted act=%h exp=%h", act_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 1, 32'h10, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    if (w_pc !== 32'h10 || w_valid !== 1'b1 || w_err !== 1'b1) begin
      errors++; $display("FAIL resume pc=%h valid=%b err=%b exp 00000010/1/1", w_pc, w_valid, w_err);
    end
    checks++;
  endtask

  task automatic test_halt_req();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (act_vec() !== exp_vec() || w_valid !== 1'b1) begin
        errors++; $display("FAIL halt_hold act=%h exp=%h", act_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (act_vec() !== exp_vec() || w_valid !== 1'b0) begin
        errors++; $display("FAIL halt_drain act=%h exp=%h", act_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 1, 32'h0, 0, 1);
    tick();
  endtask

  task automatic test_random(input int cycles);
    logic [31:0] rpc;
    for (int i = 0; i < cycles; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(4 * $urandom_range(0, 7));
      drive($urandom_range(0, 127) == 0, $urandom_range(0, 15) == 0, rpc,
            $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
      tick();
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_nowrap();
    sel_h = 1'b1; m_wrap = 1'b0;
    test_reset();
    drive(0, 0, 0, 0, 1);
    wait_for_ipc(32'h1C, "nowrap");
    if (act_data() !== 32'h00f768b3 || h_err !== 1'b1) begin
      errors++; $display("FAIL nowrap_last data=%h err=%b exp 00f768b3/1", act_data(), h_err);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (act_vec() !== exp_vec() || h_valid !== 1'b0 || h_err !== 1'b1) begin
        errors++; $display("FAIL nowrap_halt act=%h exp=%h", act_vec(), exp_vec());
      end
      checks++;
    end
    drive(0, 1, 32'h8, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    tick(); tick();
    drive(1, 0, 0, 0, 1);
    tick();
    if (h_count !== 16'h0 || h_valid !== 1'b0 || h_err !== 1'b0) begin
      errors++; $display("FAIL midreset count=%0d valid=%b err=%b exp 0/0/0", h_count, h_valid, h_err);
    end
    checks++;
    drive(0, 0, 0, 0, 1);
    tick(); tick();
    if (act_ipc() !== 32'h0 || h_valid !== 1'b1 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL midreset_first pc=%h valid=%b exp 00000000/1", act_ipc(), h_valid);
    end
    checks++;
  endtask

  task automatic test_saturation();
    sel_h = 1'b0; m_wrap = 1'b1;
    test_reset();
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) tick();
    if (w_count !== 16'hFFFF || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL saturate count=%h exp ffff", w_count);
    end
    checks++;
  endtask

  initial begin
    mem = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
            32'h00b51533, 32'h01bd5f33, 32'h00c5f633, 32'h00f768b3};
    m_wrap = 1'b1;
    sel_h  = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_bad_redirect();
    test_halt_req();
    test_random(400);
    test_nowrap();
    test_random(300);
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
